// File: rtl/soc_map_pkg.sv
// SoC memory map shared by the APB interconnect and the software-visible address map.
// Holds slave base/limit constants, slave indices and the default access timeout.
package soc_map_pkg;

    localparam int unsigned NUM_SLAVES      = 4;
    localparam int unsigned WAIT_WIDTH      = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Inclusive address windows
    localparam logic [31:0] SYSTEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] SYSTEM_LIMIT = 32'h0000_FFFF;
    localparam logic [31:0] INTC_BASE    = 32'h0C00_0000;
    localparam logic [31:0] INTC_LIMIT   = 32'h0C00_0FFF;
    localparam logic [31:0] UART_BASE    = 32'h1000_0000;
    localparam logic [31:0] UART_LIMIT   = 32'h1000_0FFF;
    localparam logic [31:0] SRAM_BASE    = 32'h8000_0000;
    localparam logic [31:0] SRAM_LIMIT   = 32'h8FFF_FFFF;

    typedef enum logic [1:0] {
        SLV_SRAM   = 2'd0,
        SLV_UART   = 2'd1,
        SLV_SYSTEM = 2'd2,
        SLV_INTC   = 2'd3
    } slave_idx_e;

    // Address is widened to 64 bits so a wider bus never aliases into the 32-bit map
    function automatic logic addr_in_range(
        input logic [63:0] addr,
        input logic [31:0] base,
        input logic [31:0] limit
    );
        return (addr >= {32'h0000_0000, base}) && (addr <= {32'h0000_0000, limit});
    endfunction

endpackage

// File: rtl/apb_decode.sv
// APB address decoder: maps paddr onto a one-hot slave vector and an unmapped flag.
// Windows are disjoint, so at most one bit of the vector is ever set.
module apb_decode
    import soc_map_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] i_paddr,
    output logic [NUM_SLAVES-1:0] o_slv_hot,
    output logic                  o_unmapped
);

    logic [63:0]           w_addr;
    logic [NUM_SLAVES-1:0] w_hit;

    assign w_addr = 64'(i_paddr);

    // Compare the address against every slave window
    always_comb begin
        w_hit             = {NUM_SLAVES{1'b0}};
        w_hit[SLV_SRAM]   = addr_in_range(w_addr, SRAM_BASE,   SRAM_LIMIT);
        w_hit[SLV_UART]   = addr_in_range(w_addr, UART_BASE,   UART_LIMIT);
        w_hit[SLV_SYSTEM] = addr_in_range(w_addr, SYSTEM_BASE, SYSTEM_LIMIT);
        w_hit[SLV_INTC]   = addr_in_range(w_addr, INTC_BASE,   INTC_LIMIT);
    end

    assign o_slv_hot  = w_hit;
    assign o_unmapped = (w_hit == {NUM_SLAVES{1'b0}});

endmodule

// File: rtl/apb_bus.sv
// APB interconnect: one master to four slaves with zero-latency response mux,
// an error response for unmapped addresses and a wait-state timeout.
module apb_bus
    import soc_map_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rts,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    input  logic                  psel,
    input  logic                  penable,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  perr,
    output logic                  sram_sel,
    output logic                  sram_enable,
    input  logic [DATA_WIDTH-1:0] sram_data,
    input  logic                  sram_ready,
    input  logic                  sram_perr,
    output logic                  uart_sel,
    output logic                  uart_enable,
    input  logic [DATA_WIDTH-1:0] uart_data,
    input  logic                  uart_ready,
    input  logic                  uart_perr,
    output logic                  system_sel,
    output logic                  system_enable,
    input  logic [DATA_WIDTH-1:0] system_data,
    input  logic                  system_ready,
    input  logic                  system_perr,
    output logic                  intc_sel,
    output logic                  intc_enable,
    input  logic [DATA_WIDTH-1:0] intc_data,
    input  logic                  intc_ready,
    input  logic                  intc_perr
);

    localparam logic [WAIT_WIDTH-1:0] TIMEOUT_CNT = WAIT_WIDTH'(TIMEOUT);

    logic [NUM_SLAVES-1:0] w_slv_hot;
    logic                  w_unmapped;
    logic                  w_active;
    logic                  w_timeout;
    logic [DATA_WIDTH-1:0] w_mux_data;
    logic                  w_mux_ready;
    logic                  w_mux_err;
    logic [WAIT_WIDTH-1:0] r_wait;
    logic                  w_unused;

    // Write-side signals are consumed by the slaves directly
    assign w_unused = ^{pdata, pwrite, pstb};

    apb_decode #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .i_paddr    (paddr),
        .o_slv_hot  (w_slv_hot),
        .o_unmapped (w_unmapped)
    );

    assign w_active  = psel && !rts;
    assign w_timeout = penable && (r_wait == TIMEOUT_CNT);

    // Slave select/enable fan-out, forced low in reset or when the master is idle
    always_comb begin
        sram_sel      = 1'b0;
        uart_sel      = 1'b0;
        system_sel    = 1'b0;
        intc_sel      = 1'b0;
        if (w_active) begin
            sram_sel   = w_slv_hot[SLV_SRAM];
            uart_sel   = w_slv_hot[SLV_UART];
            system_sel = w_slv_hot[SLV_SYSTEM];
            intc_sel   = w_slv_hot[SLV_INTC];
        end else begin
            sram_sel   = 1'b0;
            uart_sel   = 1'b0;
            system_sel = 1'b0;
            intc_sel   = 1'b0;
        end
        sram_enable   = sram_sel   && penable;
        uart_enable   = uart_sel   && penable;
        system_enable = system_sel && penable;
        intc_enable   = intc_sel   && penable;
    end

    // Response mux keyed on the one-hot decode
    always_comb begin
        w_mux_data  = {DATA_WIDTH{1'b0}};
        w_mux_ready = 1'b0;
        w_mux_err   = 1'b0;
        case (w_slv_hot)
            4'b0001: begin
                w_mux_data  = sram_data;
                w_mux_ready = sram_ready;
                w_mux_err   = sram_perr;
            end
            4'b0010: begin
                w_mux_data  = uart_data;
                w_mux_ready = uart_ready;
                w_mux_err   = uart_perr;
            end
            4'b0100: begin
                w_mux_data  = system_data;
                w_mux_ready = system_ready;
                w_mux_err   = system_perr;
            end
            4'b1000: begin
                w_mux_data  = intc_data;
                w_mux_ready = intc_ready;
                w_mux_err   = intc_perr;
            end
            default: begin
                w_mux_data  = {DATA_WIDTH{1'b0}};
                w_mux_ready = 1'b0;
                w_mux_err   = 1'b0;
            end
        endcase
    end

    // Master response: unmapped and timed-out accesses answer with an error and zero data
    always_comb begin
        prdata = {DATA_WIDTH{1'b0}};
        pready = 1'b0;
        perr   = 1'b0;
        if (!w_active) begin
            prdata = {DATA_WIDTH{1'b0}};
            pready = 1'b0;
            perr   = 1'b0;
        end else if (w_unmapped) begin
            prdata = {DATA_WIDTH{1'b0}};
            pready = penable;
            perr   = penable;
        end else if (w_timeout) begin
            prdata = {DATA_WIDTH{1'b0}};
            pready = 1'b1;
            perr   = 1'b1;
        end else begin
            prdata = w_mux_data;
            pready = w_mux_ready;
            perr   = w_mux_err;
        end
    end

    // Access-phase wait counter; restarts on every completed or abandoned transfer
    always_ff @(posedge clk) begin
        if (rts) begin
            r_wait <= {WAIT_WIDTH{1'b0}};
        end else if (!penable || pready) begin
            r_wait <= {WAIT_WIDTH{1'b0}};
        end else if (psel) begin
            r_wait <= r_wait + {{(WAIT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_wait <= {WAIT_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_apb_bus.sv
// Self-checking bench for apb_bus: directed and randomized transfers checked
// against a behavioural model of the address map and wait/timeout rules.
module tb_apb_bus;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rts;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        pwrite;
    logic [3:0]  pstb;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        perr;
    logic [3:0]  sel_v;
    logic [3:0]  en_v;
    logic [31:0] s_data [4];
    logic [3:0]  s_ready;
    logic [3:0]  s_err;

    // Slave windows in index order sram, uart, system, intc
    logic [31:0] lo_tab [4];
    logic [31:0] hi_tab [4];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_bus dut (
        .clk           (clk),
        .rts           (rts),
        .paddr         (paddr),
        .pdata         (pdata),
        .pwrite        (pwrite),
        .pstb          (pstb),
        .psel          (psel),
        .penable       (penable),
        .prdata        (prdata),
        .pready        (pready),
        .perr          (perr),
        .sram_sel      (sel_v[0]),
        .sram_enable   (en_v[0]),
        .sram_data     (s_data[0]),
        .sram_ready    (s_ready[0]),
        .sram_perr     (s_err[0]),
        .uart_sel      (sel_v[1]),
        .uart_enable   (en_v[1]),
        .uart_data     (s_data[1]),
        .uart_ready    (s_ready[1]),
        .uart_perr     (s_err[1]),
        .system_sel    (sel_v[2]),
        .system_enable (en_v[2]),
        .system_data   (s_data[2]),
        .system_ready  (s_ready[2]),
        .system_perr   (s_err[2]),
        .intc_sel      (sel_v[3]),
        .intc_enable   (en_v[3]),
        .intc_data     (s_data[3]),
        .intc_ready    (s_ready[3]),
        .intc_perr     (s_err[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if (a >= lo_tab[i] && a <= hi_tab[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Unselected slaves babble random responses that must never reach the master
    task automatic noise(input int idx);
        for (int i = 0; i < 4; i++) begin
            if (i != idx) begin
                s_data[i]  = $urandom;
                s_ready[i] = 1'($urandom_range(0, 1));
                s_err[i]   = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".sel"},    32'(sel_v),  32'h0);
        check({tag, ".en"},     32'(en_v),   32'h0);
        check({tag, ".pready"}, 32'(pready), 32'h0);
        check({tag, ".perr"},   32'(perr),   32'h0);
        check({tag, ".prdata"}, prdata,      32'h0);
    endtask

    // Access phase: slave answers after 'waits' cycles, bus gives up on access cycle TO+1
    task automatic access(input string tag, input int idx, input int waits,
                          input logic serr, input logic [31:0] data);
        logic [3:0]  exp_sel;
        logic        done;
        logic        exp_err;
        logic [31:0] exp_data;
        logic        to;
        logic        rdy;
        exp_sel = (idx >= 0) ? (4'b0001 << idx) : 4'b0000;
        done    = 1'b0;
        for (int k = 1; k <= TO + 2 && !done; k++) begin
            noise(idx);
            if (idx < 0) begin
                done     = 1'b1;
                exp_err  = 1'b1;
                exp_data = 32'h0;
            end else begin
                to           = (k - 1 == TO);
                rdy          = (k - 1 >= waits);
                s_data[idx]  = data;
                s_ready[idx] = rdy;
                s_err[idx]   = rdy & serr;
                done         = to | rdy;
                exp_err      = to | (rdy & serr);
                exp_data     = to ? 32'h0 : data;
            end
            #2;
            check({tag, ".acc_sel"}, 32'(sel_v),  32'(exp_sel));
            check({tag, ".acc_en"},  32'(en_v),   32'(exp_sel));
            check({tag, ".pready"},  32'(pready), 32'(done));
            check({tag, ".perr"},    32'(perr),   32'(exp_err));
            check({tag, ".prdata"},  prdata,      exp_data);
            if (!done) tick();
        end
    endtask

    task automatic xfer(input string tag, input logic [31:0] addr, input int waits,
                        input logic serr, input logic [31:0] data);
        int         idx;
        logic [3:0] exp_sel;
        idx     = ref_decode(addr);
        exp_sel = (idx >= 0) ? (4'b0001 << idx) : 4'b0000;
        paddr   = addr;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'($urandom_range(0, 1));
        pdata   = $urandom;
        pstb    = 4'($urandom_range(0, 15));
        noise(idx);
        if (idx >= 0) begin
            s_data[idx]  = data;
            s_ready[idx] = 1'b0;
            s_err[idx]   = 1'b0;
        end
        #2;
        check({tag, ".setup_sel"},    32'(sel_v),  32'(exp_sel));
        check({tag, ".setup_en"},     32'(en_v),   32'h0);
        check({tag, ".setup_pready"}, 32'(pready), 32'h0);
        check({tag, ".setup_perr"},   32'(perr),   32'h0);
        check({tag, ".setup_prdata"}, prdata,      (idx >= 0) ? data : 32'h0);
        tick();
        penable = 1'b1;
        access(tag, idx, waits, serr, data);
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        noise(-1);
        #2;
        check_zero({tag, ".idle"});
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        lo_tab = '{32'h8000_0000, 32'h1000_0000, 32'h0000_0000, 32'h0C00_0000};
        hi_tab = '{32'h8FFF_FFFF, 32'h1000_0FFF, 32'h0000_FFFF, 32'h0C00_0FFF};

        // Reset with an active mapped access on the bus
        rts     = 1'b1;
        paddr   = 32'h8000_0010;
        pdata   = 32'h0;
        pwrite  = 1'b0;
        pstb    = 4'h0;
        psel    = 1'b1;
        penable = 1'b1;
        s_data  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        s_ready = 4'hF;
        s_err   = 4'hF;
        tick();
        tick();
        #2;
        check_zero("reset");
        rts     = 1'b0;
        psel    = 1'b0;
        tick();
        #2;
        check_zero("psel0_penable1");
        penable = 1'b0;

        xfer("sram_read",   32'h8000_0010, 0,    1'b0, 32'hDEAD_BEEF);
        xfer("uart_write",  32'h1000_0000, 3,    1'b0, 32'h0000_00A5);
        xfer("unmapped",    32'h4000_0000, 0,    1'b0, 32'h1234_5678);
        xfer("intc_err",    32'h0C00_0004, 0,    1'b1, 32'h0BAD_F00D);
        xfer("sys_timeout", 32'h0000_0100, 1000, 1'b0, 32'h5555_AAAA);
        xfer("sys_edge_to", 32'h0000_0200, TO,   1'b0, 32'h7777_8888);
        xfer("sys_last",    32'h0000_FFFF, 1,    1'b0, 32'h0000_FFFF);
        xfer("gap_sys",     32'h0001_0000, 0,    1'b0, 32'h0);
        xfer("sram_last",   32'h8FFF_FFFC, 2,    1'b0, 32'hFFFF_0000);
        xfer("gap_sram",    32'h9000_0000, 0,    1'b0, 32'h0);
        xfer("below_sram",  32'h7FFF_FFFF, 0,    1'b0, 32'h0);
        xfer("intc_last",   32'h0C00_0FFF, 0,    1'b0, 32'hC0C0_C0C0);
        xfer("gap_intc",    32'h0C00_1000, 0,    1'b0, 32'h0);
        xfer("uart_last",   32'h1000_0FFF, 0,    1'b1, 32'h0F0F_0F0F);

        // Reset in the middle of a long sram access, then keep the access phase going
        paddr   = 32'h8000_0010;
        psel    = 1'b1;
        penable = 1'b0;
        noise(0);
        s_data[0]  = 32'hCAFE_0001;
        s_ready[0] = 1'b0;
        s_err[0]   = 1'b0;
        tick();
        penable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            noise(0);
            #2;
            check("rst_mid.wait_pready", 32'(pready), 32'h0);
            tick();
        end
        rts        = 1'b1;
        s_ready[0] = 1'b1;
        #2;
        check_zero("rst_mid.during");
        tick();
        rts = 1'b0;
        access("rst_mid.after", 0, 1000, 1'b0, 32'hCAFE_0002);
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        #2;
        check_zero("rst_mid.idle");
        xfer("post_rst_sram", 32'h8000_0020, 1, 1'b0, 32'hFEED_FACE);

        // Randomized transfers across all windows plus arbitrary addresses
        for (int t = 0; t < 24; t++) begin
            r = $urandom_range(0, 4);
            if (r < 4) a = lo_tab[r] + ($urandom % (hi_tab[r] - lo_tab[r] + 32'd1));
            else       a = $urandom;
            xfer("rnd", a, $urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
